// File: rtl/knn_dist_merge_vote.sv
// k-NN back end: squared-distance pipeline, two-list top-5 merge FSM and a
// majority voter fed by the merge result.
module knn_dist_merge_vote (
  input  logic         clk,
  input  logic         rst,
  input  logic         dist_start,
  input  logic [7:0]   x_in,
  input  logic [7:0]   y_in,
  input  logic [7:0]   x_mem,
  input  logic [7:0]   y_mem,
  output logic [17:0]  dist_out,
  output logic         dist_done,
  input  logic         merge_start,
  input  logic [99:0]  packed_odd,
  input  logic [99:0]  packed_even,
  output logic [99:0]  final_top5,
  output logic         merge_done,
  input  logic         mode,
  output logic [1:0]   predicted_class,
  output logic         class_done
);

  // ---------------- distance pipeline ----------------
  logic [7:0] xa_reg, ya_reg, xb_reg, yb_reg;
  logic [7:0] dx_reg, dy_reg;
  logic       v1_reg, v2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      dist_done <= 1'b0;
      dist_out  <= '0;
      xa_reg    <= '0;
      ya_reg    <= '0;
      xb_reg    <= '0;
      yb_reg    <= '0;
      dx_reg    <= '0;
      dy_reg    <= '0;
    end else begin
      v1_reg <= dist_start;
      if (dist_start) begin
        xa_reg <= x_in;
        ya_reg <= y_in;
        xb_reg <= x_mem;
        yb_reg <= y_mem;
      end
      // A new start while stage 1 is busy discards the older operation.
      v2_reg    <= v1_reg & ~dist_start;
      dx_reg    <= (xa_reg >= xb_reg) ? (xa_reg - xb_reg) : (xb_reg - xa_reg);
      dy_reg    <= (ya_reg >= yb_reg) ? (ya_reg - yb_reg) : (yb_reg - ya_reg);
      dist_done <= v2_reg;
      if (v2_reg)
        dist_out <= 18'(dx_reg) * 18'(dx_reg) + 18'(dy_reg) * 18'(dy_reg);
    end
  end

  // ---------------- merge FSM ----------------
  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;
  state_t state_reg, state_next;

  logic [99:0] even_reg, odd_reg, out_reg;
  logic [2:0]  pe_reg, po_reg, cnt_reg;
  logic [19:0] even_e [8];
  logic [19:0] odd_e  [8];

  // Entries past the end read as maximal so an exhausted list never wins.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_entries
      if (gi < 5) begin : g_real
        assign even_e[gi] = even_reg[20*gi +: 20];
        assign odd_e[gi]  = odd_reg[20*gi +: 20];
      end else begin : g_pad
        assign even_e[gi] = '1;
        assign odd_e[gi]  = '1;
      end
    end
  endgenerate

  logic [19:0] head_e, head_o;
  logic        take_even;
  assign head_e    = even_e[pe_reg];
  assign head_o    = odd_e[po_reg];
  assign take_even = (head_e[19:2] <= head_o[19:2]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (merge_start) state_next = RUN;
      RUN:  if (cnt_reg == 3'd4) state_next = DONE;
      DONE: state_next = HOLD;
      HOLD: if (!merge_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      even_reg   <= '0;
      odd_reg    <= '0;
      out_reg    <= '0;
      pe_reg     <= '0;
      po_reg     <= '0;
      cnt_reg    <= '0;
      final_top5 <= '0;
      merge_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      merge_done <= 1'b0;
      case (state_reg)
        IDLE: if (merge_start) begin
          even_reg <= packed_even;
          odd_reg  <= packed_odd;
          pe_reg   <= '0;
          po_reg   <= '0;
          cnt_reg  <= '0;
        end
        RUN: begin
          // Shift in from the top: after five picks the first one sits in entry 0.
          out_reg <= {(take_even ? head_e : head_o), out_reg[99:20]};
          if (take_even) pe_reg <= pe_reg + 3'd1;
          else           po_reg <= po_reg + 3'd1;
          cnt_reg <= cnt_reg + 3'd1;
        end
        DONE: begin
          final_top5 <= out_reg;
          merge_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- voter ----------------
  logic [1:0] lab [5];
  logic [2:0] count_a [5];
  logic [2:0] k_lim;
  logic [1:0] win;
  logic [2:0] best;

  assign k_lim = mode ? 3'd5 : 3'd3;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_vote
      assign lab[gi] = final_top5[20*gi +: 2];
      always_comb begin
        count_a[gi] = '0;
        for (int j = 0; j < 5; j++)
          if (3'(j) < k_lim && lab[j] == lab[gi])
            count_a[gi] = count_a[gi] + 3'd1;
      end
    end
  endgenerate

  // Strictly-greater update keeps the nearest label on a count tie.
  always_comb begin
    win  = lab[0];
    best = count_a[0];
    for (int i = 1; i < 5; i++)
      if (3'(i) < k_lim && count_a[i] > best) begin
        best = count_a[i];
        win  = lab[i];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predicted_class <= '0;
      class_done      <= 1'b0;
    end else begin
      class_done <= merge_done;
      if (merge_done) predicted_class <= win;
    end
  end

endmodule

// File: tb/tb_knn_dist_merge_vote.sv
// Bench for knn_dist_merge_vote: vector tables plus scoreboard queues checked
// whenever a done pulse appears.
module tb_knn_dist_merge_vote;

  logic         clk = 1'b0;
  logic         rst;
  logic         dist_start;
  logic [7:0]   x_in, y_in, x_mem, y_mem;
  logic [17:0]  dist_out;
  logic         dist_done;
  logic         merge_start;
  logic [99:0]  packed_odd, packed_even;
  logic [99:0]  final_top5;
  logic         merge_done;
  logic         mode;
  logic [1:0]   predicted_class;
  logic         class_done;

  knn_dist_merge_vote dut (
    .clk(clk), .rst(rst),
    .dist_start(dist_start), .x_in(x_in), .y_in(y_in), .x_mem(x_mem), .y_mem(y_mem),
    .dist_out(dist_out), .dist_done(dist_done),
    .merge_start(merge_start), .packed_odd(packed_odd), .packed_even(packed_even),
    .final_top5(final_top5), .merge_done(merge_done),
    .mode(mode), .predicted_class(predicted_class), .class_done(class_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ec = 0;
  int merges_seen = 0;

  always @(posedge clk) ec <= ec + 1;

  typedef struct { logic [17:0] d; int t; } dexp_t;
  typedef struct { logic [99:0] top; int t; } mexp_t;
  typedef struct { logic [1:0] cls; int t; } cexp_t;
  dexp_t dq[$];
  mexp_t mq[$];
  cexp_t cq[$];
  dexp_t de;
  mexp_t me;
  cexp_t ce;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ec);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pack five distances {d4..d0} and labels {l4..l0} into list format.
  function automatic logic [99:0] pk5(input logic [89:0] ds, input logic [9:0] ls);
    logic [99:0] r;
    for (int i = 0; i < 5; i++) r[20*i +: 20] = {ds[18*i +: 18], ls[2*i +: 2]};
    return r;
  endfunction

  function automatic logic [99:0] rand_list();
    logic [99:0] r;
    logic [17:0] d;
    d = 18'($urandom_range(0, 3));
    for (int i = 0; i < 5; i++) begin
      d = d + 18'($urandom_range(0, 20));
      r[20*i +: 20] = {d, 2'($urandom_range(0, 3))};
    end
    return r;
  endfunction

  // Stable selection over even-then-odd entries: ties go to the even list.
  function automatic logic [99:0] model_merge(input logic [99:0] e, input logic [99:0] o);
    logic [19:0] a [10];
    bit used [10];
    logic [99:0] r;
    int b;
    for (int i = 0; i < 5; i++) begin
      a[i] = e[20*i +: 20];
      a[i+5] = o[20*i +: 20];
    end
    for (int i = 0; i < 10; i++) used[i] = 0;
    for (int s = 0; s < 5; s++) begin
      b = -1;
      for (int j = 0; j < 10; j++)
        if (!used[j] && (b < 0 || a[j][19:2] < a[b][19:2])) b = j;
      used[b] = 1;
      r[20*s +: 20] = a[b];
    end
    return r;
  endfunction

  function automatic logic [1:0] model_vote(input logic [99:0] t, input logic md);
    int cnt [4];
    int first [4];
    int k;
    logic [1:0] l, bl;
    k = md ? 5 : 3;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; first[i] = 99; end
    for (int i = 0; i < k; i++) begin
      l = t[20*i +: 2];
      cnt[l]++;
      if (first[l] == 99) first[l] = i;
    end
    bl = t[1:0];
    for (int L = 0; L < 4; L++)
      if (cnt[L] > cnt[bl] || (cnt[L] == cnt[bl] && first[L] < first[bl])) bl = 2'(L);
    return bl;
  endfunction

  always @(negedge clk) begin
    if (dist_done) begin
      if (dq.size() == 0) chk("dist_done_unexpected", dist_done, 0);
      else begin
        de = dq.pop_front();
        chk("dist_out", dist_out, de.d);
        chk("dist_latency", ec, de.t + 2);
        $display("dist: out=%0d exp=%0d cycle=%0d", dist_out, de.d, ec);
      end
    end
    if (merge_done) begin
      merges_seen++;
      if (mq.size() == 0) chk("merge_done_unexpected", merge_done, 0);
      else begin
        me = mq.pop_front();
        chk("final_top5", final_top5, me.top);
        chk("merge_latency", ec, me.t + 6);
        $display("merge: top5=%025h cycle=%0d", final_top5, ec);
      end
    end
    if (class_done) begin
      if (cq.size() == 0) chk("class_done_unexpected", class_done, 0);
      else begin
        ce = cq.pop_front();
        chk("predicted_class", predicted_class, ce.cls);
        chk("class_latency", ec, ce.t + 7);
        $display("vote: class=%0d exp=%0d cycle=%0d", predicted_class, ce.cls, ec);
      end
    end
  end

  typedef struct { logic [7:0] x, y, xm, ym; logic [17:0] d; } dvec_t;
  typedef struct { logic [99:0] ev, od; logic md; logic [99:0] top; logic [1:0] cls; } mvec_t;
  dvec_t dt [7];
  mvec_t mt [8];

  task automatic push_merge(input logic [99:0] top, input logic [1:0] cls);
    mq.push_back('{top: top, t: ec + 1});
    cq.push_back('{cls: cls, t: ec + 1});
  endtask

  int seen0;
  int dx, dy;

  initial begin
    dt[0] = '{x: 198, y: 127, xm: 190, ym: 130, d: 73};
    dt[1] = '{x: 0,   y: 0,   xm: 255, ym: 255, d: 130050};
    dt[2] = '{x: 255, y: 255, xm: 0,   ym: 0,   d: 130050};
    dt[3] = '{x: 77,  y: 77,  xm: 77,  ym: 77,  d: 0};
    for (int i = 4; i < 7; i++) begin
      dt[i].x = 8'($urandom); dt[i].y = 8'($urandom);
      dt[i].xm = 8'($urandom); dt[i].ym = 8'($urandom);
      dx = int'(dt[i].x) - int'(dt[i].xm);
      dy = int'(dt[i].y) - int'(dt[i].ym);
      dt[i].d = 18'(dx*dx + dy*dy);
    end

    mt[0].ev = pk5({18'd25, 18'd16, 18'd9, 18'd4, 18'd1}, 10'b00_00_00_00_00);
    mt[0].od = pk5({18'd50, 18'd40, 18'd30, 18'd3, 18'd2}, 10'b01_01_01_01_01);
    mt[0].md = 1'b0;
    mt[0].top = pk5({18'd9, 18'd4, 18'd3, 18'd2, 18'd1}, {2'd0, 2'd0, 2'd1, 2'd1, 2'd0});
    mt[0].cls = 2'd1;
    mt[1] = mt[0];
    mt[1].md = 1'b1;
    mt[1].cls = 2'd0;
    mt[2].ev = pk5({5{18'd5}}, {5{2'd2}});
    mt[2].od = pk5({5{18'd5}}, {5{2'd3}});
    mt[2].md = 1'b1;
    mt[2].top = pk5({5{18'd5}}, {5{2'd2}});
    mt[2].cls = 2'd2;
    mt[3].ev = pk5({18'd70, 18'd60, 18'd50, 18'd3, 18'd1}, {2'd0, 2'd0, 2'd0, 2'd1, 2'd2});
    mt[3].od = pk5({18'd43, 18'd42, 18'd41, 18'd40, 18'd2}, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3});
    mt[3].md = 1'b0;
    mt[3].top = pk5({18'd41, 18'd40, 18'd3, 18'd2, 18'd1}, {2'd0, 2'd0, 2'd1, 2'd3, 2'd2});
    mt[3].cls = 2'd2;
    for (int i = 4; i < 8; i++) begin
      mt[i].ev = rand_list();
      mt[i].od = rand_list();
      mt[i].md = 1'($urandom_range(0, 1));
      mt[i].top = model_merge(mt[i].ev, mt[i].od);
      mt[i].cls = model_vote(mt[i].top, mt[i].md);
    end

    rst = 1'b1; dist_start = 1'b0; merge_start = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; x_mem = '0; y_mem = '0;
    packed_odd = '0; packed_even = '0;
    repeat (3) tick();
    chk("rst_dist_out", dist_out, 0);
    chk("rst_dist_done", dist_done, 0);
    chk("rst_final_top5", final_top5, 0);
    chk("rst_merge_done", merge_done, 0);
    chk("rst_predicted_class", predicted_class, 0);
    chk("rst_class_done", class_done, 0);
    rst = 1'b0;
    tick();

    // Distance vectors; operands are scrambled right after the start pulse.
    for (int i = 0; i < 7; i++) begin
      x_in = dt[i].x; y_in = dt[i].y; x_mem = dt[i].xm; y_mem = dt[i].ym;
      dist_start = 1'b1;
      dq.push_back('{d: dt[i].d, t: ec + 1});
      tick();
      dist_start = 1'b0;
      x_in = 8'($urandom); y_in = 8'($urandom); x_mem = 8'($urandom); y_mem = 8'($urandom);
      repeat (3) tick();
    end
    chk("dist_hold", dist_out, dt[6].d);

    // Restart: second start one cycle later replaces the first operation.
    x_in = 8'd0; y_in = 8'd0; x_mem = 8'd255; y_mem = 8'd255; dist_start = 1'b1;
    tick();
    x_in = 8'd10; y_in = 8'd20; x_mem = 8'd13; y_mem = 8'd16;
    dq.push_back('{d: 18'd25, t: ec + 1});
    tick();
    dist_start = 1'b0;
    repeat (4) tick();

    // Reset one cycle after a start aborts it with no done pulse.
    x_in = 8'd1; y_in = 8'd1; x_mem = 8'd2; y_mem = 8'd2; dist_start = 1'b1;
    tick();
    dist_start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("dist_abort_out", dist_out, 0);
    repeat (4) tick();

    // Merge/vote table.
    for (int i = 0; i < 8; i++) begin
      packed_even = mt[i].ev; packed_odd = mt[i].od; mode = mt[i].md;
      merge_start = 1'b1;
      push_merge(mt[i].top, mt[i].cls);
      tick();
      merge_start = 1'b0;
      packed_even = rand_list(); packed_odd = rand_list();
      repeat (9) tick();
    end

    // Level start held for 20 cycles yields exactly one merge.
    seen0 = merges_seen;
    packed_even = mt[0].ev; packed_odd = mt[0].od; mode = 1'b0;
    merge_start = 1'b1;
    push_merge(mt[0].top, mt[0].cls);
    repeat (20) tick();
    merge_start = 1'b0;
    repeat (5) tick();
    chk("level_start_one_merge", merges_seen - seen0, 1);

    // Distance and merge running concurrently.
    packed_even = mt[3].ev; packed_odd = mt[3].od; mode = mt[3].md;
    x_in = 8'd198; y_in = 8'd127; x_mem = 8'd190; y_mem = 8'd130;
    merge_start = 1'b1; dist_start = 1'b1;
    push_merge(mt[3].top, mt[3].cls);
    dq.push_back('{d: 18'd73, t: ec + 1});
    tick();
    merge_start = 1'b0; dist_start = 1'b0;
    repeat (9) tick();

    // Reset asserted at T+3 while RUN: nothing completes, outputs clear.
    seen0 = merges_seen;
    packed_even = mt[1].ev; packed_odd = mt[1].od; mode = 1'b1;
    merge_start = 1'b1;
    tick();
    merge_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_dist_out", dist_out, 0);
    chk("abort_final_top5", final_top5, 0);
    chk("abort_predicted_class", predicted_class, 0);
    repeat (10) tick();
    chk("abort_no_merge_done", merges_seen - seen0, 0);

    // Merge after the abort completes normally.
    merge_start = 1'b1;
    push_merge(mt[1].top, mt[1].cls);
    tick();
    merge_start = 1'b0;
    repeat (12) tick();

    chk("dist_queue_empty", dq.size(), 0);
    chk("merge_queue_empty", mq.size(), 0);
    chk("class_queue_empty", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knn_dist_merge_vote.md
KNN_DIST_MERGE_VOTE -- requirements
Module: knn_dist_merge_vote

Interface
REQ-001 SHALL have no parameters: coordinates 8-bit, distance 18-bit, label 2-bit, list depth 5 entries of 20 bits each.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 dist_start  input  1  one-cycle pulse; samples query and reference points.
REQ-005 x_in, y_in  input  8 each  query point coordinates.
REQ-006 x_mem, y_mem  input  8 each  reference point coordinates.
REQ-007 dist_out  output  18  squared Euclidean distance.
REQ-008 dist_done  output  1  one-cycle pulse; dist_out valid.
REQ-009 merge_start  input  1  level or pulse; requests a merge of the two lists.
REQ-010 packed_odd, packed_even  input  100 each  ascending top-5 lists.
REQ-011 final_top5  output  100  merged ascending top-5 list.
REQ-012 merge_done  output  1  one-cycle pulse; final_top5 valid.
REQ-013 mode  input  1  0 = K of 3, 1 = K of 5.
REQ-014 predicted_class  output  2  majority label.
REQ-015 class_done  output  1  one-cycle pulse; predicted_class valid.

Function
REQ-016 List packing SHALL place entry i (0 = nearest) in bits [20i+19:20i], with distance in [20i+19:20i+2] and label in [20i+1:20i].
REQ-017 Distance SHALL be (x_in-x_mem)^2 + (y_in-y_mem)^2, using absolute 8-bit differences and unsigned arithmetic; the maximum value 130050 fits in 18 bits with no saturation.
REQ-018 Distance latency: dist_start sampled at edge T -> dist_out updated and dist_done high at edge T+2.
REQ-019 Distance inputs SHALL be latched at T; changes after T SHALL NOT affect the result.
REQ-020 dist_out SHALL hold its value until the next result; a dist_start during computation SHALL restart with the new operands.
REQ-021 Merge FSM states SHALL be IDLE, RUN (5 cycles), DONE (1 cycle) and HOLD.
REQ-022 IDLE, merge_start=1 -> latch both lists, clear the two read pointers, go to RUN.
REQ-023 Each RUN cycle SHALL compare the heads of both lists, append the smaller entry to the output slot, and advance that list's pointer.
REQ-024 Ties SHALL take the even-list entry first.
REQ-025 After 5 picks the FSM SHALL go to DONE.
REQ-026 DONE SHALL update final_top5 and pulse merge_done, with merge_done at edge T+6 for start sampled at T.
REQ-027 HOLD SHALL wait until merge_start=0 before returning to IDLE, so a level start triggers exactly one merge.
REQ-028 merge_start SHALL be ignored in RUN, DONE and HOLD.
REQ-029 final_top5 SHALL hold until the next merge completes.
REQ-030 The voter SHALL trigger internally on merge_done, sampling mode and final_top5 in that same cycle.
REQ-031 The voter SHALL count the labels of entries 0..K-1.
REQ-032 The winner SHALL be the label with the highest count.
REQ-033 On a count tie, the tied label appearing at the lowest entry index (nearest) SHALL win.
REQ-034 predicted_class and class_done SHALL be registered, with class_done high one cycle after merge_done (T+7).
REQ-035 predicted_class SHALL hold until the next vote.
REQ-036 Distance and merge/vote paths SHALL operate independently and concurrently.

Reset
REQ-037 rst=1 SHALL clear dist_out, dist_done, final_top5, merge_done, predicted_class and class_done to 0.
REQ-038 rst=1 SHALL return the merge FSM to IDLE and clear all pointers, counters and in-flight distance operations.
REQ-039 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-040 Reset SHALL take priority over start in the same cycle.

Verification
REQ-041 Distance case: x_in=198, y_in=127, x_mem=190, y_mem=130, dist_start at T -> dist_out=73 and dist_done=1 at T+2 only.
REQ-042 Distance extremes: (0,0) vs (255,255) -> 130050; identical points -> 0.
REQ-043 Merge case: even distances {1,4,9,16,25} with labels {0,0,0,0,0}, odd distances {2,3,30,40,50} with labels {1,1,1,1,1}, merge_start at T.
- final_top5 distances SHALL be {1,2,3,4,9}.
- merge_done SHALL pulse at T+6 only.
- merge_start held high for 20 cycles SHALL produce exactly one merge_done.
REQ-044 Tie order: even and odd lists both all distance 5, even labels 2, odd labels 3 -> all five output labels equal 2.
REQ-045 Vote case, labels from the REQ-043 merge {0,1,1,0,0}:
- mode=0 -> predicted_class=1 at T+7;
- mode=1 -> predicted_class=0.
- Labels {2,3,1,...} with mode=0 -> predicted_class=2 (nearest-wins tie).
REQ-046 Reset: assert rst at T+3 during RUN -> no merge_done or class_done, all outputs 0; a new merge afterwards SHALL complete normally.
